bf_result_unloader: RTL

BF_RESULT_UNLOADER -- requirements
Module: bf_result_unloader

---
 rtl/bf_result_unloader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bf_result_unloader.sv
// Drains a banked result memory row by row and streams each row's lanes
// over a valid/ready word interface once the processing block finishes.
module bf_result_unloader #(
    parameter int ROWS  = 32,
    parameter int LANES = 32,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_global,
    input  logic                     finish,
    output logic [9:0]               read_address,
    input  logic [LANES*WIDTH-1:0]   mem_data,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
    localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_finish_d;
    logic [RW-1:0]          r_row;
    logic [LW-1:0]          r_lane;
    logic [LANES*WIDTH-1:0] r_buf;

    logic                   w_trigger;
    logic                   w_last_row;
    logic                   w_last_lane;
    logic                   w_hs;
    logic [LW-1:0]          w_next_lane;

    assign w_trigger   = finish & ~r_finish_d;
    assign w_last_row  = (r_row == ROW_MAX);
    assign w_last_lane = (r_lane == LANE_MAX);
    assign w_hs        = out_valid & out_ready;
    assign w_next_lane = r_lane + LW'(1);

    always_ff @(posedge clk) begin
        if (rst_global) begin
            r_state      <= S_IDLE;
            r_finish_d   <= 1'b0;
            r_row        <= '0;
            r_lane       <= '0;
            r_buf        <= '0;
            read_address <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Edge detector keeps tracking while busy so a held level never retriggers.
            r_finish_d <= finish;
            done       <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_row        <= '0;
                        read_address <= '0;
                        busy         <= 1'b1;
                        r_state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_buf     <= mem_data;
                    r_lane    <= '0;
                    out_data  <= mem_data[WIDTH-1:0];
                    out_valid <= 1'b1;
                    out_last  <= w_last_row && (LANE_MAX == '0);
                    r_state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (!w_last_lane) begin
                            r_lane   <= w_next_lane;
                            out_data <= r_buf[int'(w_next_lane)*WIDTH +: WIDTH];
                            out_last <= w_last_row && (w_next_lane == LANE_MAX);
                        end else if (!w_last_row) begin
                            r_row        <= r_row + RW'(1);
                            read_address <= 10'(r_row) + 10'd1;
                            out_valid    <= 1'b0;
                            out_last     <= 1'b0;
                            r_state      <= S_ADDR;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
